// File: rtl/apb_reg_write_arbiter_pkg.sv
// apb_reg_write_arbiter_pkg
// Shared configuration for the APB register bank and its write-side arbiter:
// the APB data width, the register-bank geometry, and a small helper used
// for the contention counter.
// No ports (package).
package apb_reg_write_arbiter_pkg;

    localparam int APB_DATA_WIDTH = 32;

    // Register-bank geometry, used by the bank and by every writer of it.
    localparam int BANK_REG_NUM = 8;
    localparam int BANK_AW      = $clog2(BANK_REG_NUM);

    // Upper bound on the number of write requesters sharing the bank port.
    localparam int MAX_REQ_NUM  = 8;

    // True when two or more bits of v are set. Clearing the lowest set bit
    // leaves something behind only if another bit was set.
    function automatic logic two_or_more(input logic [MAX_REQ_NUM-1:0] v);
        return (v & (v - MAX_REQ_NUM'(1))) != '0;
    endfunction

endpackage

// File: rtl/apb_reg_write_arbiter_rr_pick.sv
// apb_reg_write_arbiter_rr_pick
// Purely combinational round-robin priority picker. Starting just after
// the previously granted index and wrapping modulo N, it selects the first
// asserted request. Reusable by any shared-port controller.
// Ports:
//   req   in   N    request vector
//   last  in   IW   index granted most recently
//   gnt   out  N    one-hot grant (all zero when no request)
//   idx   out  IW   encoded grant index (0 when no request)
module apb_reg_write_arbiter_rr_pick #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Scan from the furthest candidate back to the nearest one; the last hit
    // written is therefore the nearest pending index after 'last'.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/apb_reg_write_arbiter.sv
// apb_reg_write_arbiter
// Shares the register bank's single write port among REQ_NUM requesters.
// Each requester has a one-entry holding slot behind a valid/ready
// handshake; pending slots are served round-robin, so an accepted write is
// never dropped. The bank-side write is registered.
// Ports:
//   clk           in   1           system clock, rising edge
//   resetn        in   1           asynchronous active-low reset
//   req_valid     in   REQ_NUM     per-requester write request
//   req_ready     out  REQ_NUM     slot can accept this cycle
//   req_addr      in   REQ_NUM*AW  packed register index, requester i at [i*AW +: AW]
//   req_wdata     in   REQ_NUM*DW  packed write data, requester i at [i*DW +: DW]
//   req_done      out  REQ_NUM     requester i's write is on the bank port this cycle
//   reg_wen       out  1           bank write enable
//   reg_waddr     out  AW          bank write index
//   reg_wdata     out  DW          bank write data
//   conflict_cnt  out  CNT_W       saturating count of cycles with >= 2 slots pending
module apb_reg_write_arbiter
    import apb_reg_write_arbiter_pkg::*;
#(
    parameter  int REQ_NUM = 2,
    parameter  int REG_NUM = BANK_REG_NUM,
    parameter  int DW      = APB_DATA_WIDTH,
    parameter  int CNT_W   = 16,
    localparam int AW      = $clog2(REG_NUM),
    localparam int IW      = $clog2(REQ_NUM)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [REQ_NUM-1:0]    req_valid,
    output logic [REQ_NUM-1:0]    req_ready,
    input  logic [REQ_NUM*AW-1:0] req_addr,
    input  logic [REQ_NUM*DW-1:0] req_wdata,
    output logic [REQ_NUM-1:0]    req_done,
    output logic                  reg_wen,
    output logic [AW-1:0]         reg_waddr,
    output logic [DW-1:0]         reg_wdata,
    output logic [CNT_W-1:0]      conflict_cnt
);

    logic [REQ_NUM-1:0] pend;
    logic [AW-1:0]      addr_q [REQ_NUM];
    logic [DW-1:0]      data_q [REQ_NUM];
    logic [IW-1:0]      last;
    logic [REQ_NUM-1:0] gnt;
    logic [IW-1:0]      gnt_idx;

    // Grant depends only on registered state, so req_ready never has a
    // combinational path from req_valid.
    apb_reg_write_arbiter_rr_pick #(
        .N (REQ_NUM)
    ) u_rr_pick (
        .req  (pend),
        .last (last),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    // A slot being drained this cycle can be refilled on the same edge,
    // which lets a lone requester stream one write per cycle.
    assign req_ready = ~pend | gnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend         <= '0;
            last         <= IW'(REQ_NUM - 1);
            reg_wen      <= 1'b0;
            reg_waddr    <= '0;
            reg_wdata    <= '0;
            req_done     <= '0;
            conflict_cnt <= '0;
            for (int i = 0; i < REQ_NUM; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // Accept takes precedence over the clear from a same-edge grant.
            for (int i = 0; i < REQ_NUM; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    pend[i]   <= 1'b1;
                    addr_q[i] <= req_addr[i*AW +: AW];
                    data_q[i] <= req_wdata[i*DW +: DW];
                end else if (gnt[i]) begin
                    pend[i] <= 1'b0;
                end
            end

            if (|gnt) begin
                last      <= gnt_idx;
                reg_wen   <= 1'b1;
                reg_waddr <= addr_q[gnt_idx];
                reg_wdata <= data_q[gnt_idx];
            end else begin
                reg_wen   <= 1'b0;
            end
            req_done <= gnt;

            if (two_or_more(MAX_REQ_NUM'(pend)) && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule
